// File: rtl/fpcvt_decode.sv
// Sequential float-to-linear decoder: D = (-1)^S * F * 2^E as 13-bit two's complement.
// Shifts the significand one bit per clock, with valid/ready handshakes on both sides.
module fpcvt_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        S,
    input  logic [2:0]  E,
    input  logic [4:0]  F,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] D
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q;
    logic [11:0] mag_q;
    logic [2:0]  cnt_q;
    logic        sgn_q;
    logic [12:0] d_q;
    logic        in_ready_q;
    logic        out_valid_q;

    logic [12:0] mag_ext;
    logic [12:0] d_d;

    // Negating a zero magnitude wraps back to zero, so -0 never yields 13'h1000.
    assign mag_ext = {1'b0, mag_q};
    assign d_d     = sgn_q ? (~mag_ext + 13'd1) : mag_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            d_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        mag_q      <= {7'b0, F};
                        cnt_q      <= E;
                        sgn_q      <= S;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q != 3'd0) begin
                        mag_q <= mag_q << 1;
                        cnt_q <= cnt_q - 3'd1;
                    end else begin
                        d_q         <= d_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // Handoff only; any in_valid this edge waits for IDLE.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign D         = d_q;
endmodule

// File: tb/tb_fpcvt_decode.sv
// Directed bench for fpcvt_decode: table of conversions plus backpressure,
// simultaneous handshake and mid-operation reset sequences.
module tb_fpcvt_decode;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        S;
    logic [2:0]  E;
    logic [4:0]  F;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] D;

    int n_checks = 0;
    int n_fail   = 0;

    fpcvt_decode dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [2:0]  e;
        logic [4:0]  f;
        logic [12:0] d;
        logic        early;   // hold out_ready high from acceptance onwards
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for out_valid; returns clocks elapsed since the call.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        string tag;
        tag = $sformatf("vec%0d", idx);
        S = v.s; E = v.e; F = v.f; in_valid = 1'b1;
        out_ready = v.early;
        tick();
        in_valid = 1'b0;
        // Scramble inputs after acceptance; result must not change.
        S = ~v.s; E = ~v.e; F = ~v.f;
        check({tag, "_in_ready_busy"}, in_ready, 0);
        wait_out(lat);
        check({tag, "_latency"}, lat, int'(v.e) + 1);
        check({tag, "_D"}, D, v.d);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_handoff"}, {out_valid, in_ready}, 2'b01);
        $display("vec%0d S=%0d E=%0d F=%0d -> D=0x%0h latency=%0d", idx, v.s, v.e, v.f, D, lat);
    endtask

    initial begin
        int lat;
        logic saw_valid;

        vecs[0] = '{1'b0, 3'd3, 5'b01101, 13'd104,    1'b1};
        vecs[1] = '{1'b0, 3'd7, 5'b11111, 13'd3968,   1'b0};
        vecs[2] = '{1'b1, 3'd7, 5'b11111, 13'h1080,   1'b0};
        vecs[3] = '{1'b0, 3'd0, 5'b00001, 13'd1,      1'b1};
        vecs[4] = '{1'b1, 3'd5, 5'b00000, 13'd0,      1'b0};
        vecs[5] = '{1'b1, 3'd4, 5'b00011, 13'h1FD0,   1'b1};
        vecs[6] = '{1'b0, 3'd0, 5'b00000, 13'd0,      1'b0};
        vecs[7] = '{1'b0, 3'd2, 5'b10101, 13'd84,     1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        S = 1'b0; E = 3'd0; F = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_state", {in_ready, out_valid, D}, {1'b1, 1'b0, 13'd0});
        for (int i = 0; i < 3; i++) tick();
        check("idle_hold", {in_ready, out_valid, D}, {1'b1, 1'b0, 13'd0});
        $display("reset: in_ready=%0d out_valid=%0d D=0x%0h", in_ready, out_valid, D);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Backpressure: -24 held while in_valid toggles with other data.
        S = 1'b1; E = 3'd2; F = 5'b00110; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        check("bp_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            S = 1'b0; E = 3'(i); F = 5'(7 * i + 3);
            tick();
            check($sformatf("bp_hold%0d", i), {out_valid, in_ready, D}, {1'b1, 1'b0, 13'h1FE8});
        end
        $display("backpressure: D=0x%0h held for 5 clks", D);

        // Simultaneous out_ready and in_valid in DONE: handoff only.
        S = 1'b0; E = 3'd1; F = 5'b00011; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("simul_handoff", {out_valid, in_ready}, 2'b01);
        tick();
        in_valid = 1'b0;
        check("simul_accept_next", in_ready, 0);
        wait_out(lat);
        check("simul_latency", lat, 2);
        check("simul_D", D, 6);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("simultaneous: new result D=%0d after deferred accept", D);

        // Reset during SHIFT with E=6.
        S = 1'b0; E = 3'd6; F = 5'b10001; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_state", {in_ready, out_valid, D}, {1'b1, 1'b0, 13'd0});
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        check("midrst_no_stale", saw_valid, 0);
        $display("mid-reset: in_ready=%0d out_valid=%0d D=0x%0h", in_ready, out_valid, D);

        // Reset recovery: normal conversion still works.
        run_vec(8, '{1'b1, 3'd1, 5'b00101, 13'h1FF6, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fpcvt_decode.md
Name: fpcvt_decode

Overview:
- Sequential inverse of the FPCVT linear-to-float converter.
- Takes a sign/exponent/significand triple (S, E[2:0], F[4:0]) and returns the 13-bit two's-complement value D = (-1)^S * F * 2^E.
- Computes the shift iteratively, one bit per clock.
- Valid/ready handshakes on both sides, so it can sit between a float producer and a linear consumer (e.g. round-trip check of FPCVT, DAC path).

Parameters:
- None. Format is fixed: 1-bit sign, 3-bit exponent, 5-bit significand in; 13-bit two's complement out.

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  S/E/F valid this cycle
- in_ready  output  1  block can accept an input
- S  input  1  sign (1 = negative)
- E  input  3  exponent, 0..7
- F  input  5  significand, unsigned 0..31
- out_valid  output  1  D holds a completed result
- out_ready  input  1  consumer accepts D this cycle
- D  output  13  two's-complement result

Behaviour:
- Reset: one clk with rst=1 sets state=IDLE, in_ready=1, out_valid=0, D=0, internal mag/cnt/sign=0. Reset has priority over every other event, including mid-SHIFT and DONE; any in-flight result is discarded.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: mag(12b) <= {7'b0,F}, cnt <= E, sgn <= S, state <= SHIFT.
  - Otherwise remain in IDLE.
- SHIFT:
  - in_ready=0.
  - If cnt!=0: mag <= mag<<1, cnt <= cnt-1.
  - If cnt==0: D <= sgn ? (~{1'b0,mag}+1) : {1'b0,mag}, out_valid <= 1, state <= DONE.
- DONE:
  - in_ready=0, out_valid=1.
  - D and out_valid are held stable while out_ready=0.
  - On out_ready=1 at an edge: out_valid <= 0, state <= IDLE. D keeps its last value; it is don't-care when out_valid=0.
- Latency: out_valid rises E+1 clocks after the accepting edge (E=0 -> 1 clock, E=7 -> 8 clocks).
- Throughput: at most one conversion per E+3 clocks. There is no overlap; in_ready is low from acceptance until the cycle after output handoff.
- Arithmetic:
  - Maximum magnitude is 31*2^7 = 3968, which fits in 12 bits, so no overflow or saturation logic is needed.
  - Negation is a 13-bit two's complement.
- Boundary conditions:
  - F=0 with any S or E -> D=0. Negative zero must produce 0, never 13'h1000.
  - Non-normalized F (MSB 0) is decoded literally, with no error flag.
  - in_valid asserted while not in IDLE is ignored. S/E/F are sampled only at the accepting edge, so later input changes do not affect the result.
  - out_ready asserted while not in DONE has no effect.
  - Simultaneous in_valid and out_ready in DONE: the output is handed off; the input is not accepted that edge. It is accepted in IDLE next cycle if still valid.

Test Plan:
- rst=1 for 2 clk, then release -> in_ready=1, out_valid=0, D=0; hold 3 idle clks with in_valid=0 -> no change.
- S=0,E=3,F=01101, out_ready=1 -> out_valid high 4 clks after accept, D=0_0000_0110_1000 (104); in_ready=1 the clock after handoff.
- S=0,E=7,F=11111 -> latency 8, D=0_1111_1000_0000 (3968). Then S=1,E=7,F=11111 -> D=1_0000_1000_0000 (-3968).
- S=0,E=0,F=00001 -> latency 1, D=1. Then S=1,E=5,F=00000 -> D=0 (not 13'h1000).
- Backpressure: S=1,E=2,F=00110, out_ready=0 for 5 clks -> D=1_1111_1110_1000 (-24) held stable, out_valid=1, in_ready=0. Toggle in_valid with other data during this window -> ignored; after out_ready=1 the next result reflects only new inputs accepted in IDLE.
- Reset mid-operation: accept E=6, assert rst at the 3rd SHIFT clk -> next edge state=IDLE, out_valid=0, D=0, no stale result ever appears.
